// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs decoded instruction fields into 32-bit words, buffers them
//            in a FIFO and writes them sequentially into instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [2:0]        rd,
    input  logic [2:0]        r1,
    input  logic [2:0]        r2,
    input  logic [7:0]        i1,
    input  logic [7:0]        i2,
    input  logic              mem_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic [7:0]        err_count,
    output logic [ADDR_W:0]   words_written,
    output logic              region_full
);

    localparam int                C_PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [C_PTR_W:0]  C_FULL  = (C_PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_fifo [DEPTH];
    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_PTR_W:0]     r_count;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W:0]      r_words;
    logic                 r_err;
    logic [7:0]           r_err_count;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_legal;
    logic                 w_mov;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last;
    logic [31:0]          w_word;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == C_FULL);
    assign w_legal  = (opcode >= 6'd1) && (opcode <= 6'd7);
    assign w_mov    = (opcode == 6'd3);
    assign w_last   = (r_addr == '1);

    // ALU ops drop the immediates, MOV drops the source registers
    assign w_word = {opcode, rd,
                     w_mov ? 3'd0 : r1,
                     w_mov ? 3'd0 : r2,
                     w_mov ? i1 : 8'd0,
                     w_mov ? i2 : 8'd0,
                     1'b0};

    assign in_ready = !w_full && (r_state != S_HALT);
    assign mem_we   = !w_empty && !mem_stall && (r_state == S_RUN);
    assign w_accept = in_valid && in_ready && !clear;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = mem_we;

    assign mem_addr      = r_addr;
    assign mem_wdata     = w_empty ? 32'd0 : r_fifo[r_rd_ptr];
    assign err           = r_err;
    assign err_count     = r_err_count;
    assign words_written = r_words;
    assign region_full   = (r_state == S_HALT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)          w_state_nxt = S_RUN;
            S_RUN:   if (w_pop && w_last)   w_state_nxt = S_HALT;
            S_HALT:                         w_state_nxt = S_HALT;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset: occupancy and pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_addr      <= C_BASE;
            r_words     <= '0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (C_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (C_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
                r_words  <= r_words + (ADDR_W+1)'(1);
                // The final address is held; the HALT transition stops further writes
                if (!w_last) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
            r_err <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire
